// File: rtl/portreq.sv
// Write-request queue presenting the head entry to an arbiter, with a starvation flag.
// Define PORTREQ_BYPASS_EN to let an empty queue present the incoming request combinationally.
module portreq #(
  parameter int unsigned a          = 9,
  parameter int unsigned w          = 128,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [a-1:0]             in_addr,
  input  logic [w-1:0]             in_data,
  input  logic                     flush,
  output logic                     csel,
  output logic [a-1:0]             addr,
  output logic [w-1:0]             data,
  input  logic                     grnt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     starved
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [a+w-1:0] mem [DEPTH];
  logic [a+w-1:0] head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    wait_q, wait_d;
  logic          active_q;

  logic full, q_valid, byp, push, pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    q_valid  = (count_q != '0);
    // active_q keeps in_ready low until the first edge after reset release
    in_ready = active_q & ~full & ~flush;
`ifdef PORTREQ_BYPASS_EN
    byp      = ~q_valid & in_valid & in_ready;
`else
    byp      = 1'b0;
`endif
    csel     = q_valid | byp;
    head     = mem[rd_ptr_q];
    if (q_valid) begin
      addr = head[a+w-1:w];
      data = head[w-1:0];
    end else if (byp) begin
      addr = in_addr;
      data = in_data;
    end else begin
      addr = '0;
      data = '0;
    end
    starved  = (wait_q >= 8'(STARVE_LIM));
  end

  always_comb begin
    pop      = q_valid & grnt & ~flush;
    // A bypassed request granted in the same cycle completes without being stored
    push     = in_valid & in_ready & ~(byp & grnt);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wait_d   = wait_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wait_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (!csel || grnt) begin
        wait_d = '0;
      end else if (wait_q != 8'hff) begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      active_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      active_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= {in_addr, in_data};
  end

  assign count = count_q;

endmodule

// File: tb/tb_portreq.sv
// Directed self-checking bench for portreq at default parameters (DEPTH=4, STARVE_LIM=15).
// Honours PORTREQ_BYPASS_EN where same-cycle presentation changes the expected timing.
module tb_portreq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   in_addr;
  logic [127:0] in_data;
  logic         flush;
  logic         csel;
  logic [8:0]   addr;
  logic [127:0] data;
  logic         grnt;
  logic [2:0]   count;
  logic         starved;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PORTREQ_BYPASS_EN
  localparam int PreWait = 1;
`else
  localparam int PreWait = 0;
`endif

  portreq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .flush    (flush),
    .csel     (csel),
    .addr     (addr),
    .data     (data),
    .grnt     (grnt),
    .count    (count),
    .starved  (starved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_one(input logic [8:0] ad, input logic [127:0] dt);
    in_valid = 1'b1;
    in_addr  = ad;
    in_data  = dt;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    flush    = 1'b0;
    grnt     = 1'b0;
    #3;
    check("rst_csel",     128'(csel),     128'h0);
    check("rst_addr",     128'(addr),     128'h0);
    check("rst_data",     data,           128'h0);
    check("rst_starved",  128'(starved),  128'h0);
    check("rst_in_ready", 128'(in_ready), 128'h0);
    check("rst_count",    128'(count),    128'h0);
    #9 rst_n = 1'b1;
    tick();
    check("rel_in_ready", 128'(in_ready), 128'h1);

    // Single push with grant tied high
    grnt     = 1'b1;
    in_valid = 1'b1;
    in_addr  = 9'h1A5;
    in_data  = 128'hDEAD_BEEF;
`ifdef PORTREQ_BYPASS_EN
    #1;
    check("single_byp_csel", 128'(csel), 128'h1);
    check("single_byp_addr", 128'(addr), 128'h1A5);
    tick();
    in_valid = 1'b0;
    #1;
    check("single_byp_count", 128'(count), 128'h0);
    check("single_byp_csel0", 128'(csel),  128'h0);
`else
    #1;
    check("single_pre_csel", 128'(csel), 128'h0);
    tick();
    in_valid = 1'b0;
    #1;
    check("single_csel",  128'(csel),  128'h1);
    check("single_addr",  128'(addr),  128'h1A5);
    check("single_data",  data,        128'hDEAD_BEEF);
    check("single_count", 128'(count), 128'h1);
    tick();
    check("single_csel0",  128'(csel),  128'h0);
    check("single_count0", 128'(count), 128'h0);
`endif
    grnt = 1'b0;

    // Fill to DEPTH, refuse a fifth, drain in order
    for (int i = 1; i <= 4; i++) push_one(9'(i), 128'(i * 256));
    #1;
    check("fill_count",    128'(count),    128'h4);
    check("fill_in_ready", 128'(in_ready), 128'h0);
    push_one(9'h005, 128'h500);
    check("fill_refused", 128'(count), 128'h4);
    grnt = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_addr", 128'(addr), 128'(i));
      check("drain_data", data, 128'(i * 256));
      tick();
    end
    grnt = 1'b0;
    check("drain_count", 128'(count), 128'h0);
    check("drain_csel",  128'(csel),  128'h0);
    check("drain_addr0", 128'(addr),  128'h0);

    // Full with simultaneous pop: no push that cycle, accepted on the next
    for (int i = 1; i <= 4; i++) push_one(9'(16 + i), 128'(16 + i));
    in_valid = 1'b1;
    in_addr  = 9'h015;
    in_data  = 128'h15;
    grnt     = 1'b1;
    tick();
    grnt = 1'b0;
    #1;
    check("fullpop_count", 128'(count), 128'h3);
    tick();
    in_valid = 1'b0;
    check("fullpop_push", 128'(count), 128'h4);
    grnt = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1;
      check("fullpop_order", 128'(addr), 128'(16 + i));
      tick();
    end
    grnt = 1'b0;
    check("fullpop_empty", 128'(count), 128'h0);

    // Starvation threshold, hold, and clear on grant
    push_one(9'h040, 128'h40);
    for (int k = 1; k < 15 - PreWait; k++) tick();
    check("starve_below", 128'(starved), 128'h0);
    tick();
    check("starve_rise", 128'(starved), 128'h1);
    for (int k = 0; k < 5; k++) tick();
    check("starve_hold", 128'(starved), 128'h1);
    grnt = 1'b1;
    tick();
    grnt = 1'b0;
    check("starve_clear", 128'(starved), 128'h0);
    check("starve_count", 128'(count),   128'h0);

    // Flush with concurrent push and grant
    for (int i = 1; i <= 3; i++) push_one(9'(80 + i), 128'(80 + i));
    check("flush_pre_count", 128'(count), 128'h3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 9'h099;
    in_data  = 128'h99;
    grnt     = 1'b1;
    #1;
    check("flush_in_ready", 128'(in_ready), 128'h0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    grnt     = 1'b0;
    #1;
    check("flush_count", 128'(count), 128'h0);
    check("flush_csel",  128'(csel),  128'h0);
    check("flush_addr",  128'(addr),  128'h0);
    push_one(9'h061, 128'h61);
    #1;
    check("flush_after_addr",  128'(addr),  128'h061);
    check("flush_after_count", 128'(count), 128'h1);

    // Asynchronous reset between edges drops queued entries
    push_one(9'h072, 128'h72);
    check("areset_pre_count", 128'(count), 128'h2);
    rst_n = 1'b0;
    #1;
    check("areset_csel",     128'(csel),     128'h0);
    check("areset_count",    128'(count),    128'h0);
    check("areset_addr",     128'(addr),     128'h0);
    check("areset_in_ready", 128'(in_ready), 128'h0);
    #1 rst_n = 1'b1;
    tick();
    check("areset_rel_ready", 128'(in_ready), 128'h1);
    check("areset_rel_csel",  128'(csel),     128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
